// File: rtl/minterm_table_engine.sv
// ----------------------------------------------------------------------------
// minterm_table_engine
//   Programmable sum-of-minterms engine. A 2**NIN-deep table holds NOUT output
//   functions per input vector. The table is loaded serially, can be read at
//   random through a registered evaluation port, and can be streamed out in
//   full by an exhaustive sweep.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   cfg_start      pulse: begin table load (honoured only in IDLE)
//   cfg_valid      cfg_data holds the entry for the current load address
//   cfg_ready      engine accepts an entry this cycle (high only in LOAD)
//   cfg_data       entry {f[NOUT-1]..f[0]} for the current load address
//   cfg_done       one-cycle pulse after the last entry is written
//   eval_in        input vector for random-access evaluation
//   eval_out       table[eval_in], one cycle of latency
//   sweep_start    pulse: begin exhaustive sweep (honoured only in IDLE)
//   busy           engine is not in IDLE
//   sw_valid       sw_vec/sw_out/sw_last carry a sweep beat
//   sw_ready       downstream accepts the current sweep beat
//   sw_vec         current sweep input vector
//   sw_out         table[sw_vec]
//   sw_last        current beat is the all-ones vector
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. The producer keeps valid and its payload steady until that transfer;
// ready may change freely and never depends combinationally on valid.
// ----------------------------------------------------------------------------
module minterm_table_engine #(
    parameter int NIN  = 4,
    parameter int NOUT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [NOUT-1:0] cfg_data,
    output logic            cfg_done,
    input  logic [NIN-1:0]  eval_in,
    output logic [NOUT-1:0] eval_out,
    input  logic            sweep_start,
    output logic            busy,
    output logic            sw_valid,
    input  logic            sw_ready,
    output logic [NIN-1:0]  sw_vec,
    output logic [NOUT-1:0] sw_out,
    output logic            sw_last
);

    localparam int             DEPTH     = 1 << NIN;
    localparam logic [NIN-1:0] LAST_ADDR = {NIN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t          state;
    logic [NIN-1:0]  addr;
    logic [NOUT-1:0] tbl [DEPTH];

    // Control FSM and table storage. Reset clears the whole table so that a
    // load interrupted by reset never leaves a partially written table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            busy      <= 1'b0;
            sw_valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    // cfg_start has priority when both starts arrive together.
                    if (cfg_start) begin
                        state     <= LOAD;
                        addr      <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else if (sweep_start) begin
                        state    <= SWEEP;
                        addr     <= '0;
                        sw_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        tbl[addr] <= cfg_data;
                        // Leave before the counter would wrap.
                        if (addr == LAST_ADDR) begin
                            state     <= IDLE;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else begin
                            addr <= addr + NIN'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (sw_valid && sw_ready) begin
                        if (addr == LAST_ADDR) begin
                            state    <= IDLE;
                            sw_valid <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            addr <= addr + NIN'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    sw_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Random-access read. A write landing on the same entry in the same cycle
    // is not forwarded: the old contents are returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_out <= '0;
        end else begin
            eval_out <= tbl[eval_in];
        end
    end

    // Sweep payload comes straight from the address register and the table;
    // neither changes during a stall, so the beat holds while sw_ready is low.
    // Outside a sweep the payload is forced to zero.
    always_comb begin
        sw_vec  = '0;
        sw_out  = '0;
        sw_last = 1'b0;
        if (sw_valid) begin
            sw_vec  = addr;
            sw_out  = tbl[addr];
            sw_last = (addr == LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_minterm_table_engine.sv
// ----------------------------------------------------------------------------
// tb_minterm_table_engine
//   Self-checking bench for minterm_table_engine (NIN=4, NOUT=2). A reference
//   copy of the table is kept in the bench; sweep and evaluation expectations
//   are pushed into exp_q as stimulus is driven and popped as the DUT answers.
// ----------------------------------------------------------------------------
module tb_minterm_table_engine;

    localparam int NIN   = 4;
    localparam int NOUT  = 2;
    localparam int DEPTH = 1 << NIN;
    localparam int W     = NIN + NOUT + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [NOUT-1:0] cfg_data;
    logic            cfg_done;
    logic [NIN-1:0]  eval_in;
    logic [NOUT-1:0] eval_out;
    logic            sweep_start;
    logic            busy;
    logic            sw_valid;
    logic            sw_ready;
    logic [NIN-1:0]  sw_vec;
    logic [NOUT-1:0] sw_out;
    logic            sw_last;

    minterm_table_engine #(.NIN(NIN), .NOUT(NOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_done    (cfg_done),
        .eval_in     (eval_in),
        .eval_out    (eval_out),
        .sweep_start (sweep_start),
        .busy        (busy),
        .sw_valid    (sw_valid),
        .sw_ready    (sw_ready),
        .sw_vec      (sw_vec),
        .sw_out      (sw_out),
        .sw_last     (sw_last)
    );

    // ---------------- scoreboard ----------------
    logic [NOUT-1:0] tbl [DEPTH];
    logic [W-1:0]    exp_q [$];
    int              n_vec  = 0;
    int              n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NOUT-1:0] make_entry(input int mode, input int i);
        logic [3:0] v;
        v = 4'(i);
        if (mode == 0) return {v[3], ^v};
        return NOUT'($urandom_range(0, (1 << NOUT) - 1));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    endtask

    // ---------------- driver tasks ----------------
    // Table load. gaps: randomly drop cfg_valid. abort_at: assert reset at
    // that beat (-1 = never). contend: raise sweep_start with cfg_start and
    // again in the middle of the load.
    task automatic load_table(input int mode, input int gaps, input int abort_at, input int contend);
        int i;
        int cyc;
        i   = 0;
        cyc = 0;
        @(posedge clk); #1;
        cfg_start   = 1'b1;
        sweep_start = (contend != 0);
        @(posedge clk); #1;
        cfg_start   = 1'b0;
        sweep_start = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        while (i < DEPTH && cyc < 200) begin
            cyc++;
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = make_entry(mode, i);
            end
            eval_in     = NIN'(i);
            sweep_start = (contend != 0 && i == 3);
            @(negedge clk);
            check("cfg_ready", 32'(cfg_ready), 32'd1);
            check("sw_valid_in_load", 32'(sw_valid), 32'd0);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_cfg_ready", 32'(cfg_ready), 32'd0);
                clear_model();
                @(posedge clk); #1;
                check("abort_busy_held", 32'(busy), 32'd0);
                cfg_valid   = 1'b0;
                sweep_start = 1'b0;
                rst_n       = 1'b1;
                return;
            end
            @(posedge clk); #1;
            // Same-cycle write to the read address returns the old contents.
            check("eval_old", 32'(eval_out), 32'(tbl[i]));
            if (cfg_valid) begin
                tbl[i] = cfg_data;
                i++;
            end
        end
        cfg_valid   = 1'b0;
        sweep_start = 1'b0;
        if (i < DEPTH) check("load_timeout", 32'(i), 32'(DEPTH));
        check("cfg_done", 32'(cfg_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_cfg_ready", 32'(cfg_ready), 32'd0);
        check("done_sw_valid", 32'(sw_valid), 32'd0);
        @(posedge clk); #1;
        check("cfg_done_pulse", 32'(cfg_done), 32'd0);
        check("no_queued_sweep", 32'(sw_valid), 32'd0);
    endtask

    // Sweep. mode 0: sw_ready always high; 1: pattern 1,0,0,1; 2: random.
    task automatic run_sweep(input int mode);
        int pat [4] = '{1, 0, 0, 1};
        int cyc;
        @(posedge clk); #1;
        sweep_start = 1'b1;
        for (int v = 0; v < DEPTH; v++) begin
            exp_q.push_back({NIN'(v), tbl[v], (v == DEPTH - 1)});
        end
        @(posedge clk); #1;
        sweep_start = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (mode == 0)      sw_ready = 1'b1;
            else if (mode == 1) sw_ready = pat[cyc % 4][0];
            else                sw_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("sw_valid", 32'(sw_valid), 32'd1);
            if (sw_valid) begin
                // Compared against the queue head every cycle, so a beat that
                // moves during a stall or is skipped/duplicated shows up here.
                check("sw_beat", 32'({sw_vec, sw_out, sw_last}), 32'(exp_q[0]));
                if (sw_ready) void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        sw_ready = 1'b0;
        if (exp_q.size() > 0) begin
            check("sweep_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        check("sweep_end_valid", 32'(sw_valid), 32'd0);
        check("sweep_end_busy", 32'(busy), 32'd0);
        check("sweep_end_last", 32'(sw_last), 32'd0);
    endtask

    // Random-access evaluation of every entry.
    task automatic eval_sweep();
        for (int v = 0; v < DEPTH; v++) begin
            @(posedge clk); #1;
            eval_in = NIN'(v);
            exp_q.push_back(W'(tbl[v]));
            @(posedge clk); #1;
            check("eval_out", 32'(eval_out), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n       = 1'b0;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        eval_in     = '0;
        sweep_start = 1'b0;
        sw_ready    = 1'b0;
        clear_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_cfg_done", 32'(cfg_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sw_valid", 32'(sw_valid), 32'd0);
        check("rst_outputs", 32'({eval_out, sw_vec, sw_out, sw_last}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        eval_sweep();                 // all entries read zero after reset
        load_table(0, 0, -1, 0);      // entry i = {i[3], ^i}
        eval_sweep();
        run_sweep(0);                 // full-rate sweep
        run_sweep(1);                 // 1,0,0,1 backpressure
        load_table(1, 1, 5, 0);       // reset at beat 5
        run_sweep(0);                 // table must read all zero
        eval_sweep();
        load_table(1, 1, -1, 1);      // start contention, random data, gaps
        run_sweep(2);
        eval_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
